// File: rtl/meta_sweep_ctrl_pkg.sv
// Shared types and defaults for the meta_detector window sweep controller.
// Holds the FSM state encoding, parameter defaults and the saturation ceiling.
package meta_sweep_ctrl_pkg;

  localparam int unsigned SEL_W_DEF      = 4;
  localparam int unsigned CNT_W_DEF      = 16;
  localparam int unsigned SETTLE_CYC_DEF = 8;

  // All-ones ceiling; counters slice the low CNT_W bits as their saturation value.
  localparam logic [31:0] CNT_SAT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_REPORT  = 3'd3,
    ST_FINISH  = 3'd4
  } sweep_state_t;

endpackage

// File: rtl/sat_err_counter.sv
// Error-cycle counter with registered clear and enable; holds at all-ones
// instead of wrapping.
module sat_err_counter
  import meta_sweep_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] SAT_MAX = CNT_SAT_MAX[CNT_W-1:0];

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != SAT_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/meta_sweep_ctrl.sv
// Steps meta_detector.win_sel across a programmed range, counts error cycles
// per setting, streams each count out and keeps the best setting seen.
//
// state      | meaning
// IDLE       | waiting for start
// SETTLE     | win_sel just changed, let delay line and synchronizers settle
// MEASURE    | count registered error cycles for max(meas_len,1) cycles
// REPORT     | result presented on res_*, wait for res_ready
// FINISH     | one-cycle done pulse, then back to IDLE
module meta_sweep_ctrl
  import meta_sweep_ctrl_pkg::*;
#(
  parameter int unsigned SEL_W      = SEL_W_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SEL_W-1:0] sel_lo,
  input  logic [SEL_W-1:0] sel_hi,
  input  logic [CNT_W-1:0] meas_len,
  input  logic             error,
  output logic [SEL_W-1:0] win_sel,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SEL_W-1:0] res_sel,
  output logic [CNT_W-1:0] res_count,
  output logic             done,
  output logic [SEL_W-1:0] best_sel,
  output logic [CNT_W-1:0] best_count
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYC);
  localparam int unsigned TMR_W = (CNT_W > SET_W) ? CNT_W : SET_W;
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);

  sweep_state_t     r_state;
  sweep_state_t     w_state_nxt;
  logic [SEL_W-1:0] r_win_sel;
  logic [SEL_W-1:0] r_sel_hi;
  logic [CNT_W-1:0] r_meas_len;
  logic [TMR_W-1:0] r_timer;
  logic [SEL_W-1:0] r_best_sel;
  logic [CNT_W-1:0] r_best_count;
  logic             r_err_q;

  logic             w_accept;
  logic             w_range_ok;
  logic             w_tmr_zero;
  logic             w_clr_cnt;
  logic             w_cnt_en;
  logic             w_hs;
  logic             w_last;
  logic             w_busy;
  logic             w_res_valid;
  logic             w_done;
  logic [CNT_W-1:0] w_meas_last;
  logic [CNT_W-1:0] w_count;

  assign w_range_ok  = (sel_lo <= sel_hi);
  assign w_tmr_zero  = (r_timer == '0);
  assign w_last      = (r_win_sel == r_sel_hi);
  // meas_len of zero still measures for one cycle.
  assign w_meas_last = (r_meas_len == '0) ? '0 : (r_meas_len - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_clr_cnt   = 1'b0;
    w_cnt_en    = 1'b0;
    w_hs        = 1'b0;
    w_busy      = 1'b1;
    w_res_valid = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = w_range_ok ? ST_SETTLE : ST_FINISH;
        end
      end
      ST_SETTLE: begin
        if (w_tmr_zero) begin
          w_clr_cnt   = 1'b1;
          w_state_nxt = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        w_cnt_en = r_err_q;
        if (w_tmr_zero) begin
          w_state_nxt = ST_REPORT;
        end
      end
      ST_REPORT: begin
        w_res_valid = 1'b1;
        if (res_ready) begin
          w_hs        = 1'b1;
          w_state_nxt = w_last ? ST_FINISH : ST_SETTLE;
        end
      end
      ST_FINISH: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_q      <= 1'b0;
      r_win_sel    <= '0;
      r_sel_hi     <= '0;
      r_meas_len   <= '0;
      r_timer      <= '0;
      r_best_sel   <= '0;
      r_best_count <= '0;
    end else begin
      r_err_q <= error;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sel_hi     <= sel_hi;
            r_meas_len   <= meas_len;
            r_best_sel   <= '0;
            r_best_count <= '0;
            r_timer      <= SETTLE_LOAD;
            if (w_range_ok) begin
              r_win_sel <= sel_lo;
            end
          end
        end
        ST_SETTLE: begin
          r_timer <= w_tmr_zero ? TMR_W'(w_meas_last) : (r_timer - TMR_W'(1));
        end
        ST_MEASURE: begin
          if (!w_tmr_zero) begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        ST_REPORT: begin
          if (w_hs) begin
            // Strict compare keeps the lower setting on ties.
            if (w_count > r_best_count) begin
              r_best_sel   <= r_win_sel;
              r_best_count <= w_count;
            end
            // Checked before incrementing so the top setting never wraps.
            if (!w_last) begin
              r_win_sel <= r_win_sel + SEL_W'(1);
              r_timer   <= SETTLE_LOAD;
            end
          end
        end
        default: ;
      endcase
    end
  end

  sat_err_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr_cnt),
    .i_en    (w_cnt_en),
    .o_count (w_count)
  );

  assign win_sel    = r_win_sel;
  assign busy       = w_busy;
  assign res_valid  = w_res_valid;
  assign res_sel    = r_win_sel;
  assign res_count  = w_count;
  assign done       = w_done;
  assign best_sel   = r_best_sel;
  assign best_count = r_best_count;

endmodule
